player_input: RTL and testbench
===============================

# player_input

Input-side front end for the two-player light-cycle game. It turns raw, asynchronous 4-button direction pads into the one-hot `p1_info` / `p2_info` direction codes consumed by the frame-rate drawing/position logic. The block synchronizes and debounces each button and forbids 180° reversals. It commits direction changes only at the frame-update tick, so each code is constant for an entire frame.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz); must be ≥ 1.
- `CNT_W`, localparam: `$clog2(DEBOUNCE_CYCLES+1)`.

- `clock`  in  1  system clock; the block is single-clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `frame_tick`  in  1  one-cycle pulse at the last pixel of the frame (row 599, col 799); the same condition the drawing logic uses to latch positions.
- `dflt`  in  1  synchronous game-restart; returns both players to STOP.
- `p1_btn`  in  4  raw player-1 buttons, asynchronous, active-high; bit order matches the direction codes.
- `p2_btn`  in  4  raw player-2 buttons, same encoding.
- `p1_info`  out  4  committed player-1 direction code; 0 at reset.
- `p2_info`  out  4  committed player-2 direction code; 0 at reset.

## Operation
- Direction codes:
  - `4'b0001`: y−1.
  - `4'b0010`: y+1.
  - `4'b0100`: x−1.
  - `4'b1000`: x+1.
  - STOP is `4'b0000`.
  - Opposite pairs are 0001↔0010 and 0100↔1000.
- Debounce, per button bit:
  - Two-flop synchronizer (s1, s2) feeds a counter compared against a `stable` level.
  - While s2 equals `stable`, the counter is held at 0.
  - While s2 differs, the counter increments. When it has seen DEBOUNCE_CYCLES consecutive differing cycles, `stable` toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `stable`.
  - `press` is `stable & ~stable_prev`, where `stable_prev` is a registered copy of `stable`. It is high for exactly one cycle per accepted press.
- Per-player command logic, two identical instances. Each holds `cur` (output register), `pend` (4 bits) and `pend_v`.
  - States: IDLE (`cur` == STOP) and MOVING (`cur` != STOP).
  - Valid press event: exactly one `press` bit is high in the cycle. Cycles with zero or with two or more press bits are ignored.
  - Reference direction: the value `cur` takes at this clock edge, which is `pend` if `frame_tick && pend_v`, else `cur`.
  - A valid press whose code is the opposite of the reference direction is discarded.
  - Any other valid press loads `pend` and sets `pend_v`. A later press overwrites an earlier uncommitted one.
  - A press equal to the reference direction is accepted; this is harmless.
  - On `frame_tick` with `pend_v`: `cur` ← `pend`, `pend_v` ← 0. The transition is IDLE→MOVING on the first press, or MOVING→MOVING with the new direction.
  - If a valid press arrives in the same cycle as such a tick, it is checked against the newly committed direction and becomes the next `pend`.
  - No transition ever returns to STOP except via `reset` or `dflt`.
- `dflt`: `cur` ← STOP and `pend_v` ← 0 for both players. It overrides any same-cycle tick or press. Debouncer state is kept, so a button held through the restart does not re-fire.
- `reset`: clears synchronizers, counters, `stable`, `stable_prev`, `pend`, `pend_v` and `cur` to 0.

## Timing
- Raw rising edge first sampled at edge E → s2 high after E+1 → `stable` set at edge E+1+DEBOUNCE_CYCLES → `press` high during the following cycle → `pend_v` set at edge E+2+DEBOUNCE_CYCLES.
- `pX_info` changes only at the edge where `frame_tick` is sampled high. It is stable for the whole following frame, including the next tick cycle.
- Outputs are registered; there is no combinational path from any input to `pX_info`.
- Release is debounced identically and produces no event.

## Structure
- Shared package `tron_pkg`:
  - `dir_t` codes `DIR_YM`, `DIR_YP`, `DIR_XM`, `DIR_XP`, `DIR_STOP`.
  - Function `dir_opposite(dir_t)`.
  - The drawing logic imports the same package.
- Sub-module `button_debounce`, parameterized by DEBOUNCE_CYCLES, holds the synchronizer, counter, `stable` and `press`. It is instantiated 8 times.
- The per-player command logic is a generate loop over the two players inside `player_input`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and `frame_tick` every 50 cycles.
- Reset, no buttons → `p1_info`=`p2_info`=0 for 3 frames.
- `p1_btn`=0001 held 10 cycles → `pend_v` set exactly 6 edges after first sample; `p1_info`=0001 after the next tick, unchanged until then.
- Current 0100, press 1000 → ignored, `p1_info` stays 0100. Press 0001 then 0010 within one frame → 0010 committed, because the reference direction is still 0100.
- 3-cycle pulse on bit 1 → no change. Pressing 0011 simultaneously → no event.
- Press captured in the same cycle as the tick that commits the previous pend → old `pend` is committed now and the new press is committed at the next tick. Reversal is checked against the new `cur`.
- `dflt` pulse in the same cycle as a tick with `pend_v` → both outputs 0 and `pend_v` cleared. A button held through `dflt` produces no new event until it is released and pressed again.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared light-cycle definitions: one-hot direction codes and helpers.
// Imported by the input front end and by the drawing/position logic.
package tron_pkg;

    localparam int unsigned DIR_W     = 4;
    localparam int unsigned N_PLAYERS = 2;

    // One-hot movement codes; STOP is the all-zero code.
    typedef enum logic [DIR_W-1:0] {
        DIR_STOP = 4'b0000,
        DIR_YM   = 4'b0001,
        DIR_YP   = 4'b0010,
        DIR_XM   = 4'b0100,
        DIR_XP   = 4'b1000
    } dir_t;

    // 180-degree reversal of a direction; STOP has no opposite.
    function automatic dir_t dir_opposite(input dir_t d);
        case (d)
            DIR_YM:  return DIR_YP;
            DIR_YP:  return DIR_YM;
            DIR_XM:  return DIR_XP;
            DIR_XP:  return DIR_XM;
            default: return DIR_STOP;
        endcase
    endfunction

    // True when exactly one button reported a press this cycle.
    function automatic logic is_single_press(input logic [DIR_W-1:0] v);
        return (v != '0) && ((v & (v - DIR_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/player_input_if.sv
// Game-side bundle between the input front end and the rest of the game.
//   frame_tick : one-cycle pulse at the last pixel of each frame
//   dflt       : synchronous game restart
//   p1_btn/p2_btn   : raw asynchronous direction pads
//   p1_info/p2_info : committed one-hot direction codes
// master drives the pads/ticks and reads the codes; slave is the front end.
interface player_input_if;
    import tron_pkg::*;

    logic             frame_tick;
    logic             dflt;
    logic [DIR_W-1:0] p1_btn;
    logic [DIR_W-1:0] p2_btn;
    logic [DIR_W-1:0] p1_info;
    logic [DIR_W-1:0] p2_info;

    modport master (
        output frame_tick, dflt, p1_btn, p2_btn,
        input  p1_info, p2_info
    );

    modport slave (
        input  frame_tick, dflt, p1_btn, p2_btn,
        output p1_info, p2_info
    );

endinterface

// File: rtl/button_debounce.sv
// Single-button synchronizer + debouncer with a one-cycle press pulse.
//   clock, reset : system clock, synchronous active-high reset
//   btn          : raw asynchronous button level
//   press_c      : high for one cycle after an accepted rising level
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press_c
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_prev;
    logic [CNT_W-1:0] cnt;

    // Synchronize, then accept a new level only after it persists long enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            cnt         <= '0;
        end else begin
            s1          <= btn;
            s2          <= s1;
            stable_prev <= stable;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press_c = stable & ~stable_prev;

endmodule

// File: rtl/player_input.sv
// Two-player direction front end: debounces pads, rejects reversals and
// commits one direction change per frame at frame_tick.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : player_input_if.slave (ticks, restart, pads, codes)
module player_input
    import tron_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic           clock,
    input  logic           reset,
    player_input_if.slave  bus
);

    logic [DIR_W-1:0] btn_raw [N_PLAYERS];
    logic [DIR_W-1:0] info    [N_PLAYERS];

    assign btn_raw[0]  = bus.p1_btn;
    assign btn_raw[1]  = bus.p2_btn;
    assign bus.p1_info = info[0];
    assign bus.p2_info = info[1];

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        logic [DIR_W-1:0] press_c;
        dir_t             cur;
        dir_t             pend;
        logic             pend_v;
        logic             commit_c;
        logic             accept_c;
        dir_t             ref_dir_c;

        for (genvar b = 0; b < DIR_W; b++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock   (clock),
                .reset   (reset),
                .btn     (btn_raw[p][b]),
                .press_c (press_c[b])
            );
        end

        // A press is judged against the direction cur holds after this edge.
        always_comb begin
            commit_c  = bus.frame_tick && pend_v;
            ref_dir_c = commit_c ? pend : cur;
            accept_c  = is_single_press(press_c) &&
                        (dir_t'(press_c) != dir_opposite(ref_dir_c));
        end

        // IDLE (cur == STOP) / MOVING command register; restart beats tick and press.
        always_ff @(posedge clock) begin
            if (reset) begin
                cur    <= DIR_STOP;
                pend   <= DIR_STOP;
                pend_v <= 1'b0;
            end else if (bus.dflt) begin
                cur    <= DIR_STOP;
                pend_v <= 1'b0;
            end else begin
                if (commit_c) begin
                    cur    <= pend;
                    pend_v <= 1'b0;
                end
                if (accept_c) begin
                    pend   <= dir_t'(press_c);
                    pend_v <= 1'b1;
                end
            end
        end

        assign info[p] = cur;
    end

endmodule

// File: tb/tb_player_input.sv
// Self-checking bench for player_input with a window-based behavioural model.
module tb_player_input;

    localparam int DB    = 4;
    localparam int FRAME = 50;

    logic clock;
    logic reset;
    int   phase;
    int   n_cmp;
    int   n_bad;

    player_input_if bus ();

    player_input #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: raw sample history, accepted levels, commands.
    logic [3:0] msamp [2][DB+2];
    logic [3:0] mstab [2];
    logic [3:0] mprev [2];
    logic [3:0] mcur  [2];
    logic [3:0] mpend [2];
    logic       mpv   [2];

    function automatic logic [3:0] m_opp(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    // A level is accepted once the DB samples seen through the two-stage
    // delay all disagree with the current accepted level.
    task automatic model_edge();
        logic [3:0] btn [2];
        logic [3:0] press;
        logic [3:0] refd;
        bit         all_diff;
        btn[0] = bus.p1_btn;
        btn[1] = bus.p2_btn;
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                mcur[p]  = 4'b0;
                mpend[p] = 4'b0;
                mpv[p]   = 1'b0;
                mstab[p] = 4'b0;
                mprev[p] = 4'b0;
                for (int i = 0; i < DB + 2; i++) msamp[p][i] = 4'b0;
            end else begin
                press = mstab[p] & ~mprev[p];
                if (bus.dflt) begin
                    mcur[p] = 4'b0;
                    mpv[p]  = 1'b0;
                end else begin
                    refd = (bus.frame_tick && mpv[p]) ? mpend[p] : mcur[p];
                    if (bus.frame_tick && mpv[p]) begin
                        mcur[p] = mpend[p];
                        mpv[p]  = 1'b0;
                    end
                    if ($countones(press) == 1 && press != m_opp(refd)) begin
                        mpend[p] = press;
                        mpv[p]   = 1'b1;
                    end
                end
                for (int i = DB + 1; i > 0; i--) msamp[p][i] = msamp[p][i-1];
                msamp[p][0] = btn[p];
                mprev[p] = mstab[p];
                for (int b = 0; b < 4; b++) begin
                    all_diff = 1'b1;
                    for (int i = 2; i <= DB + 1; i++)
                        if (msamp[p][i][b] == mstab[p][b]) all_diff = 1'b0;
                    if (all_diff) mstab[p][b] = ~mstab[p][b];
                end
            end
        end
    endtask

    // One clock: model follows the edge, then the frame tick schedule advances.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        phase = (phase == FRAME - 1) ? 0 : phase + 1;
        bus.frame_tick = (phase == FRAME - 1);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (phase == target) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hold(3);
        n_cmp++;
        if (bus.p1_info !== 4'b0 || bus.p2_info !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_value: p1=%b p2=%b expected 0000/0000", bus.p1_info, bus.p2_info);
        end
        reset = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            n_cmp++;
            if (bus.p1_info !== 4'b0 || bus.p2_info !== 4'b0) begin
                n_bad++;
                $display("FAIL idle_frames cyc %0d: p1=%b p2=%b expected 0000/0000", i, bus.p1_info, bus.p2_info);
            end
        end
    endtask

    task automatic test_glitch();
        wait_phase(5);
        bus.p1_btn = 4'b0010;
        bus.p2_btn = 4'b0010;
        hold(3);
        bus.p1_btn = 4'b0000;
        hold(1);
        bus.p2_btn = 4'b0000;
        hold(10);
        bus.p1_btn = 4'b0011;
        hold(8);
        bus.p1_btn = 4'b0000;
        wait_phase(0);
        n_cmp++;
        if (bus.p1_info !== 4'b0000) begin
            n_bad++;
            $display("FAIL glitch_short_or_dual: p1=%b expected 0000", bus.p1_info);
        end
        n_cmp++;
        if (bus.p2_info !== 4'b0010) begin
            n_bad++;
            $display("FAIL glitch_exact_length: p2=%b expected 0010", bus.p2_info);
        end
    endtask

    task automatic test_latency();
        wait_phase(42);
        bus.p1_btn = 4'b0001;
        step();
        bus.p2_btn = 4'b0100;
        hold(6);
        n_cmp++;
        if (bus.p1_info !== 4'b0000 || bus.p2_info !== 4'b0010) begin
            n_bad++;
            $display("FAIL latency_before_tick: p1=%b p2=%b expected 0000/0010", bus.p1_info, bus.p2_info);
        end
        step();
        n_cmp++;
        if (bus.p1_info !== 4'b0001) begin
            n_bad++;
            $display("FAIL latency_commit_in_time: p1=%b expected 0001", bus.p1_info);
        end
        n_cmp++;
        if (bus.p2_info !== 4'b0010) begin
            n_bad++;
            $display("FAIL latency_pend_at_tick: p2=%b expected 0010", bus.p2_info);
        end
        hold(3);
        bus.p1_btn = 4'b0000;
        bus.p2_btn = 4'b0000;
        wait_phase(0);
        n_cmp++;
        if (bus.p2_info !== 4'b0100 || bus.p1_info !== 4'b0001) begin
            n_bad++;
            $display("FAIL latency_next_frame: p1=%b p2=%b expected 0001/0100", bus.p1_info, bus.p2_info);
        end
    endtask

    task automatic test_reversal();
        wait_phase(2);
        bus.p2_btn = 4'b1000;
        hold(8);
        bus.p2_btn = 4'b0000;
        wait_phase(0);
        n_cmp++;
        if (bus.p2_info !== 4'b0100) begin
            n_bad++;
            $display("FAIL reversal_ignored: p2=%b expected 0100", bus.p2_info);
        end
        wait_phase(2);
        bus.p2_btn = 4'b0001;
        hold(8);
        bus.p2_btn = 4'b0000;
        wait_phase(28);
        bus.p2_btn = 4'b0010;
        hold(8);
        bus.p2_btn = 4'b0000;
        wait_phase(0);
        n_cmp++;
        if (bus.p2_info !== 4'b0010) begin
            n_bad++;
            $display("FAIL reversal_ref_is_cur: p2=%b expected 0010", bus.p2_info);
        end
        n_cmp++;
        if (bus.p1_info !== 4'b0001) begin
            n_bad++;
            $display("FAIL reversal_other_player: p1=%b expected 0001", bus.p1_info);
        end
    endtask

    task automatic test_back_to_back();
        // Press lands on the commit edge and is judged against the new cur.
        wait_phase(2);
        bus.p1_btn = 4'b0100;
        hold(8);
        bus.p1_btn = 4'b0000;
        wait_phase(43);
        bus.p1_btn = 4'b1000;
        wait_phase(0);
        n_cmp++;
        if (bus.p1_info !== 4'b0100) begin
            n_bad++;
            $display("FAIL b2b_commit_old: p1=%b expected 0100", bus.p1_info);
        end
        hold(3);
        bus.p1_btn = 4'b0000;
        wait_phase(0);
        n_cmp++;
        if (bus.p1_info !== 4'b0100) begin
            n_bad++;
            $display("FAIL b2b_reverse_of_new: p1=%b expected 0100", bus.p1_info);
        end
        wait_phase(2);
        bus.p1_btn = 4'b0001;
        hold(8);
        bus.p1_btn = 4'b0000;
        wait_phase(43);
        bus.p1_btn = 4'b1000;
        wait_phase(0);
        n_cmp++;
        if (bus.p1_info !== 4'b0001) begin
            n_bad++;
            $display("FAIL b2b_commit_old2: p1=%b expected 0001", bus.p1_info);
        end
        hold(3);
        bus.p1_btn = 4'b0000;
        wait_phase(0);
        n_cmp++;
        if (bus.p1_info !== 4'b1000) begin
            n_bad++;
            $display("FAIL b2b_new_pend: p1=%b expected 1000", bus.p1_info);
        end
    endtask

    task automatic test_dflt();
        wait_phase(5);
        bus.p1_btn = 4'b0001;
        hold(8);
        bus.p1_btn = 4'b0000;
        wait_phase(20);
        bus.p2_btn = 4'b0100;
        wait_phase(FRAME - 1);
        bus.dflt = 1'b1;
        step();
        bus.dflt = 1'b0;
        n_cmp++;
        if (bus.p1_info !== 4'b0000 || bus.p2_info !== 4'b0000) begin
            n_bad++;
            $display("FAIL dflt_over_tick: p1=%b p2=%b expected 0000/0000", bus.p1_info, bus.p2_info);
        end
        wait_phase(0);
        n_cmp++;
        if (bus.p1_info !== 4'b0000 || bus.p2_info !== 4'b0000) begin
            n_bad++;
            $display("FAIL dflt_pend_cleared: p1=%b p2=%b expected 0000/0000", bus.p1_info, bus.p2_info);
        end
        wait_phase(2);
        bus.p2_btn = 4'b0000;
        hold(8);
        bus.p2_btn = 4'b0100;
        hold(8);
        bus.p2_btn = 4'b0000;
        wait_phase(0);
        n_cmp++;
        if (bus.p2_info !== 4'b0100 || bus.p1_info !== 4'b0000) begin
            n_bad++;
            $display("FAIL dflt_repress: p1=%b p2=%b expected 0000/0100", bus.p1_info, bus.p2_info);
        end
    endtask

    task automatic test_random();
        int         left [2];
        logic [3:0] val;
        left[0] = 0;
        left[1] = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (left[p] == 0) begin
                    case ($urandom_range(0, 3))
                        0:       val = 4'b0000;
                        1, 2:    val = 4'(1 << $urandom_range(0, 3));
                        default: val = 4'($urandom_range(0, 15));
                    endcase
                    if (p == 0) bus.p1_btn = val;
                    else        bus.p2_btn = val;
                    left[p] = $urandom_range(1, 12);
                end
                left[p]--;
            end
            bus.dflt = ($urandom_range(0, 299) == 0);
            step();
            n_cmp++;
            if (bus.p1_info !== mcur[0]) begin
                n_bad++;
                $display("FAIL random_p1 cyc %0d: p1=%b expected %b", cyc, bus.p1_info, mcur[0]);
            end
            n_cmp++;
            if (bus.p2_info !== mcur[1]) begin
                n_bad++;
                $display("FAIL random_p2 cyc %0d: p2=%b expected %b", cyc, bus.p2_info, mcur[1]);
            end
        end
        bus.dflt   = 1'b0;
        bus.p1_btn = 4'b0000;
        bus.p2_btn = 4'b0000;
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        phase          = 0;
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.dflt       = 1'b0;
        bus.p1_btn     = 4'b0000;
        bus.p2_btn     = 4'b0000;

        test_reset();
        test_glitch();
        test_latency();
        test_reversal();
        test_back_to_back();
        test_dflt();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
